// File: rtl/wb_slave_bfm.sv
// wb_slave_bfm: Wishbone B3 slave exposing each request to an attached response model that acks or errors every beat
module wb_slave_bfm #(
  parameter int aw = 32,
  parameter int dw = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o,
  input  logic            rsp_valid_i,
  input  logic            rsp_err_i,
  input  logic [dw-1:0]   rsp_dat_i,
  output logic [aw-1:0]   address_o,
  output logic [dw/8-1:0] mask_o,
  output logic            op_o,
  output logic            cycle_type_o,
  output logic            has_next_o,
  output logic [dw-1:0]   wdat_o
);
  localparam int sw = dw/8;
  typedef enum logic {IDLE, BEAT} state_t;
  state_t state_q;
  logic [aw-1:0] address_q, wrap_m, next_adr_d;
  logic [sw-1:0] mask_q;
  logic [dw-1:0] wdat_q;
  logic op_q, burst_q, req, hit, cont;
  assign req = wb_cyc_i & wb_stb_i;
  assign hit = (state_q == BEAT) & req & rsp_valid_i;
  assign wb_ack_o = hit & ~rsp_err_i;
  assign wb_err_o = hit & rsp_err_i;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = (wb_ack_o & ~op_q) ? rsp_dat_i : '0;
  assign cont = burst_q & (wb_cti_i != 3'b111);
  // wrapped bursts keep the upper address bits and roll over inside the aligned block
  assign wrap_m = wb_bte_i == 2'b01 ? aw'(4*sw-1) :
                  wb_bte_i == 2'b10 ? aw'(8*sw-1) :
                  wb_bte_i == 2'b11 ? aw'(16*sw-1) : '1;
  assign next_adr_d = wb_cti_i == 3'b001 ? address_q :
                      (address_q & ~wrap_m) | ((address_q + aw'(sw)) & wrap_m);
  assign address_o = address_q;
  assign mask_o = mask_q;
  assign op_o = op_q;
  assign cycle_type_o = burst_q;
  assign has_next_o = state_q == BEAT;
  assign wdat_o = wdat_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      address_q <= '0;
      mask_q <= '0;
      op_q <= 1'b0;
      burst_q <= 1'b0;
      wdat_q <= '0;
    end else if (state_q == IDLE) begin
      if (req) begin
        state_q <= BEAT;
        address_q <= wb_adr_i;
        mask_q <= wb_sel_i;
        op_q <= wb_we_i;
        burst_q <= (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);
      end
    end else if (!req || wb_err_o) begin
      state_q <= IDLE;
    end else if (wb_ack_o) begin
      state_q <= cont ? BEAT : IDLE;
      address_q <= cont ? next_adr_d : wb_adr_i;
      mask_q <= wb_sel_i;
      if (op_q) wdat_q <= wb_dat_i;
    end
  end
endmodule

// File: tb/tb_wb_slave_bfm.sv
// tb_wb_slave_bfm: directed checks of request capture, ack/err timing and burst addressing
module tb_wb_slave_bfm;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o, rsp_dat_i = '0, address_o, wdat_o;
  logic [3:0] wb_sel_i = '0, mask_o;
  logic [2:0] wb_cti_i = '0;
  logic [1:0] wb_bte_i = '0;
  logic wb_we_i = 0, wb_cyc_i = 0, wb_stb_i = 0, rsp_valid_i = 0, rsp_err_i = 0;
  logic wb_ack_o, wb_err_o, wb_rty_o, op_o, cycle_type_o, has_next_o;
  int checks = 0, errors = 0;

  wb_slave_bfm dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o), .rsp_valid_i(rsp_valid_i), .rsp_err_i(rsp_err_i), .rsp_dat_i(rsp_dat_i),
    .address_o(address_o), .mask_o(mask_o), .op_o(op_o), .cycle_type_o(cycle_type_o),
    .has_next_o(has_next_o), .wdat_o(wdat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic cyc, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    wb_cyc_i = cyc; wb_stb_i = cyc; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = bte;
  endtask

  task automatic burst(input string tag, input logic [2:0] cti, input logic [1:0] bte,
                       input logic [31:0] exp [4]);
    bus(1, 0, exp[0], 0, 4'hF, cti, bte);
    tick();
    chk({tag, " type"}, cycle_type_o, 1);
    rsp_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      rsp_dat_i = 32'h100 + i;
      @(negedge clk);
      chk({tag, " ack"}, wb_ack_o, 1);
      chk({tag, " adr"}, address_o, exp[i]);
      chk({tag, " dat"}, wb_dat_o, 32'h100 + i);
      tick();
      if (i < 3) begin
        chk({tag, " has_next"}, has_next_o, 1);
        bus(1, 0, exp[i+1], 0, 4'hF, (i == 2) ? 3'b111 : cti, bte);
      end
    end
    bus(0, 0, 0, 0, 0, 0, 0);
    rsp_valid_i = 0;
    chk({tag, " end has_next"}, has_next_o, 0);
    @(negedge clk);
    chk({tag, " end ack"}, wb_ack_o, 0);
  endtask

  initial begin
    logic [31:0] incr_a [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] wrap_a [4] = '{32'h8, 32'hC, 32'h0, 32'h4};
    logic [31:0] const_a [4] = '{32'h20, 32'h20, 32'h20, 32'h20};
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("reset ack", wb_ack_o, 0);
    chk("reset err", wb_err_o, 0);
    chk("reset dat", wb_dat_o, 0);
    chk("reset has_next", has_next_o, 0);
    // classic write
    bus(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
    @(negedge clk);
    chk("wr pre ack", wb_ack_o, 0);
    tick();
    rsp_valid_i = 1;
    @(negedge clk);
    chk("wr ack", wb_ack_o, 1);
    chk("wr op", op_o, 1);
    chk("wr adr", address_o, 32'h10);
    tick();
    bus(0, 0, 0, 0, 0, 0, 0);
    rsp_valid_i = 0;
    chk("wr data", wdat_o, 32'hDEADBEEF);
    chk("wr mask", mask_o, 4'hF);
    chk("wr has_next", has_next_o, 0);
    chk("wr ack pulse", wb_ack_o, 0);
    // classic read, zero delay
    bus(1, 0, 32'h10, 0, 4'hF, 3'b000, 2'b00);
    tick();
    rsp_valid_i = 1; rsp_dat_i = 32'hCAFE0001;
    @(negedge clk);
    chk("rd ack", wb_ack_o, 1);
    chk("rd dat", wb_dat_o, 32'hCAFE0001);
    chk("rd type", cycle_type_o, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0, 0);
    rsp_valid_i = 0;
    chk("rd has_next", has_next_o, 0);
    chk("rd ack pulse", wb_ack_o, 0);
    burst("incr", 3'b010, 2'b00, incr_a);
    burst("wrap4", 3'b010, 2'b01, wrap_a);
    burst("const", 3'b001, 2'b00, const_a);
    // error termination
    bus(1, 0, 32'h40, 0, 4'hF, 3'b000, 2'b00);
    tick();
    rsp_valid_i = 1; rsp_err_i = 1;
    @(negedge clk);
    chk("err err", wb_err_o, 1);
    chk("err ack", wb_ack_o, 0);
    tick();
    bus(0, 0, 0, 0, 0, 0, 0);
    rsp_valid_i = 0; rsp_err_i = 0;
    chk("err pulse", wb_err_o, 0);
    chk("err has_next", has_next_o, 0);
    // reset in the middle of a burst
    bus(1, 0, 32'h0, 0, 4'hF, 3'b010, 2'b00);
    tick();
    rsp_valid_i = 1; rsp_dat_i = 32'h55;
    tick();
    bus(1, 0, 32'h4, 0, 4'hF, 3'b010, 2'b00);
    rst = 1;
    tick();
    chk("rst ack", wb_ack_o, 0);
    chk("rst err", wb_err_o, 0);
    chk("rst dat", wb_dat_o, 0);
    chk("rst has_next", has_next_o, 0);
    rst = 0;
    bus(0, 0, 0, 0, 0, 0, 0);
    rsp_valid_i = 0;
    tick(); tick();
    chk("rst idle has_next", has_next_o, 0);
    // classic read with two cycles of wrapper delay
    bus(1, 0, 32'h24, 0, 4'hF, 3'b000, 2'b00);
    tick();
    rsp_dat_i = 32'h12345678;
    @(negedge clk);
    chk("dly ack0", wb_ack_o, 0);
    chk("dly adr", address_o, 32'h24);
    tick();
    @(negedge clk);
    chk("dly ack1", wb_ack_o, 0);
    tick();
    rsp_valid_i = 1;
    @(negedge clk);
    chk("dly ack2", wb_ack_o, 1);
    chk("dly dat", wb_dat_o, 32'h12345678);
    tick();
    bus(0, 0, 0, 0, 0, 0, 0);
    rsp_valid_i = 0;
    chk("dly has_next", has_next_o, 0);
    chk("rty", wb_rty_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
